// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared state encoding and pixel word type for the frame streamer.
package frame_stream_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    typedef logic [31:0] pixel_t;

endpackage

// File: rtl/frame_streamer_pixel_fifo.sv
// pixel_fifo: synchronous pixel buffer with occupancy count and combinational head read.
module pixel_fifo
    import frame_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pixel_t                   wdata,
    input  logic                     pop,
    output pixel_t                   rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    pixel_t         mem [DEPTH];
    logic [AW-1:0]  wp, rp;

    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    assign rdata = mem[rp];

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: fetches one frame of pixels from memory under a credit limit and streams them out.
module frame_streamer
    import frame_stream_pkg::*;
#(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10,
    parameter int ADDR_W      = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reload_bg,
    input  logic [WIDTH_BITS-1:0]  width,
    input  logic [HEIGHT_BITS-1:0] height,
    input  logic [ADDR_W-1:0]      base_addr,
    output logic                   mem_rd_req,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic                   mem_rd_ready,
    input  logic                   mem_rd_valid,
    input  logic [31:0]            mem_rd_data,
    output logic                   enable,
    output pixel_t                 rbg_pixel,
    output pixel_t                 memory_pixel,
    output logic                   last_in_frame,
    output logic                   wr_background,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int TW = WIDTH_BITS + HEIGHT_BITS;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state, state_nx;
    logic [TW-1:0]   total, req_idx, pix_cnt;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]   outstanding, fifo_count;
    logic            bg_pending, bg_flag, en_q, pop, resp, req_acc, start_ok, credit;
    pixel_t          fifo_rdata, pix_q, d1, d2;

    assign start_ok    = start && state == IDLE;
    assign resp        = mem_rd_valid && state != IDLE;
    assign pop         = fifo_count != '0;
    assign credit      = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign mem_rd_req  = state == FETCH && credit;
    assign mem_rd_addr = base + ADDR_W'({req_idx, 2'b00});
    assign req_acc     = mem_rd_req && mem_rd_ready;

    assign enable        = en_q;
    assign rbg_pixel     = pix_q;
    assign memory_pixel  = d2;
    assign last_in_frame = en_q && pix_cnt == total - TW'(1);
    assign wr_background = en_q && bg_flag;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp),
        .wdata (mem_rd_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx   = state;
        busy       = state != IDLE;
        frame_done = state == DONE;
        case (state)
            IDLE:  if (start) state_nx = (width == '0 || height == '0) ? DONE : FETCH;
            FETCH: if (req_acc && req_idx == total - TW'(1)) state_nx = DRAIN;
            DRAIN: if (last_in_frame) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            total       <= '0;
            base        <= '0;
            req_idx     <= '0;
            pix_cnt     <= '0;
            outstanding <= '0;
            bg_pending  <= 1'b1;
            bg_flag     <= 1'b0;
            en_q        <= 1'b0;
            pix_q       <= '0;
            d1          <= '0;
            d2          <= '0;
        end else begin
            if (start_ok) begin
                total      <= TW'(width) * TW'(height);
                base       <= base_addr & ~ADDR_W'(3);
                req_idx    <= '0;
                pix_cnt    <= '0;
                bg_flag    <= bg_pending | reload_bg;
                bg_pending <= 1'b0;
            end else begin
                if (reload_bg) bg_pending <= 1'b1;
                if (req_acc) req_idx <= req_idx + TW'(1);
                if (en_q) pix_cnt <= pix_cnt + TW'(1);
            end
            outstanding <= outstanding + CW'(req_acc) - CW'(resp);
            en_q        <= pop;
            if (pop) pix_q <= fifo_rdata;
            d1 <= pix_q;
            d2 <= d1;
        end

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed scenarios against a latency/ready-configurable memory model.
module tb_frame_streamer;

    logic        clk = 0, rst = 1, start = 0, reload_bg = 0;
    logic [10:0] width = 0;
    logic [9:0]  height = 0;
    logic [31:0] base_addr = 0;
    logic        mem_rd_req, mem_rd_ready = 1, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data, rbg_pixel, memory_pixel;
    logic        enable, last_in_frame, wr_background, busy, frame_done;

    int checks = 0, errors = 0;
    int lat = 1;
    bit toggle = 0;

    logic [7:0]  sr_v = '0;
    logic [31:0] sr_d [8] = '{default: 0};

    logic [31:0] px_q[$], addr_q[$];
    bit          last_q[$], bg_q[$];
    int          en_cyc_q[$];
    int cyc = 0, acc_tot = 0, en_tot = 0, req_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int credit_err = 0, stall_err = 0, mp_err = 0, hist_ok = 0, done_base = 0;
    bit prev_stall = 0;
    logic [31:0] prev_addr = 0, h0 = 0, h1 = 0;

    frame_streamer dut (
        .clk(clk), .rst(rst), .start(start), .reload_bg(reload_bg),
        .width(width), .height(height), .base_addr(base_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .enable(enable), .rbg_pixel(rbg_pixel), .memory_pixel(memory_pixel),
        .last_in_frame(last_in_frame), .wr_background(wr_background),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[9:2] ^ 8'h3C, a[17:10] + 8'h11, a[7:0] ^ a[15:8], 8'h00};
    endfunction

    assign mem_rd_valid = sr_v[0];
    assign mem_rd_data  = sr_d[0];

    // memory: fixed latency of lat cycles from acceptance to valid response
    always @(posedge clk) begin
        for (int k = 0; k < 7; k++) begin
            sr_v[k] <= sr_v[k+1];
            sr_d[k] <= sr_d[k+1];
        end
        sr_v[7] <= 1'b0;
        if (mem_rd_req && mem_rd_ready) begin
            sr_v[lat-1] <= 1'b1;
            sr_d[lat-1] <= pat(mem_rd_addr);
        end
        mem_rd_ready <= toggle ? ~mem_rd_ready : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            acc_tot = 0; en_tot = 0; prev_stall = 0; hist_ok = 0;
        end else begin
            if (enable) begin
                px_q.push_back(rbg_pixel); last_q.push_back(last_in_frame);
                bg_q.push_back(wr_background); en_cyc_q.push_back(cyc); en_tot++;
            end
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
            if (mem_rd_req) req_cnt++;
            if (start && !busy) start_cyc = cyc;
            if (acc_tot - en_tot > 4) credit_err++;
            if (prev_stall && (!mem_rd_req || mem_rd_addr !== prev_addr)) stall_err++;
            prev_stall = mem_rd_req && !mem_rd_ready;
            prev_addr = mem_rd_addr;
            if (mem_rd_req && mem_rd_ready) begin acc_tot++; addr_q.push_back(mem_rd_addr); end
            if (hist_ok >= 2 && memory_pixel !== h1) mp_err++;
            h1 = h0; h0 = rbg_pixel;
            if (hist_ok < 2) hist_ok++;
        end
    end

    task automatic start_frame(input logic [10:0] w, input logic [9:0] h, input logic [31:0] b);
        width = w; height = h; base_addr = b;
        px_q.delete(); addr_q.delete(); last_q.delete(); bg_q.delete(); en_cyc_q.delete();
        done_base = done_cnt;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(output bit to);
        for (int i = 0; i < 3000 && done_cnt == done_base; i++) @(negedge clk);
        to = done_cnt == done_base;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reload;
        @(posedge clk); #1 reload_bg = 1;
        @(posedge clk); #1 reload_bg = 0;
    endtask

    task automatic do_reset;
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd_req, enable, last_in_frame, wr_background, busy, frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_rd_req, enable, last_in_frame, wr_background, busy, frame_done});
        end
        checks++;
        if ({rbg_pixel, memory_pixel} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h expected 0/0", rbg_pixel, memory_pixel);
        end
        @(posedge clk); #1 rst = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_frame;
        bit to;
        int bad = 0;
        start_frame(4, 2, 32'h0000_1000);
        wait_done(to);
        checks++;
        if (to !== 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", to); end
        checks++;
        if (px_q.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", px_q.size()); end
        for (int i = 0; i < px_q.size(); i++) begin
            checks++;
            if (px_q[i] !== pat(32'h1000 + 4*i) || last_q[i] !== (i == 7)) begin
                errors++;
                $display("FAIL basic_pix%0d: got %h last %0d expected %h last %0d",
                         i, px_q[i], last_q[i], pat(32'h1000 + 4*i), i == 7);
            end
        end
        if (px_q.size() == 8) begin
            checks++;
            if (en_cyc_q[7] - en_cyc_q[0] != 7) begin
                errors++; $display("FAIL basic_consecutive: got span %0d expected 7", en_cyc_q[7] - en_cyc_q[0]);
            end
            checks++;
            if (done_cyc != en_cyc_q[7] + 1) begin
                errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, en_cyc_q[7] + 1);
            end
        end
        foreach (addr_q[i]) if (addr_q[i] !== 32'h1000 + 4*i) bad++;
        checks++;
        if (addr_q.size() != 8 || bad != 0) begin
            errors++; $display("FAIL basic_addr: got %0d reqs %0d bad expected 8 reqs 0 bad", addr_q.size(), bad);
        end
    endtask

    task automatic test_stall;
        bit to;
        int bad = 0, abad = 0;
        lat = 5; toggle = 1;
        start_frame(5, 3, 32'h2000_0012);
        wait_done(to);
        lat = 1; toggle = 0;
        checks++;
        if (to !== 0) begin errors++; $display("FAIL stall_timeout: got %0d expected 0", to); end
        checks++;
        if (px_q.size() != 15) begin errors++; $display("FAIL stall_count: got %0d expected 15", px_q.size()); end
        foreach (px_q[i]) if (px_q[i] !== pat(32'h2000_0010 + 4*i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_data: got %0d bad pixels expected 0", bad); end
        foreach (addr_q[i]) if (addr_q[i] !== 32'h2000_0010 + 4*i) abad++;
        checks++;
        if (abad != 0) begin errors++; $display("FAIL stall_addr: got %0d bad addrs expected 0", abad); end
        checks++;
        if (credit_err != 0) begin errors++; $display("FAIL stall_credit: got %0d overruns expected 0", credit_err); end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_err); end
    endtask

    task automatic test_background;
        bit to;
        int ones;
        do_reset();
        start_frame(2, 2, 32'h500);
        wait_done(to);
        ones = 0; foreach (bg_q[i]) ones += bg_q[i];
        checks++;
        if (to !== 0 || bg_q.size() != 4 || ones != 4) begin
            errors++; $display("FAIL bg_frame_a: got %0d of %0d set expected 4 of 4", ones, bg_q.size());
        end
        start_frame(3, 1, 32'h600);
        pulse_reload();
        wait_done(to);
        ones = 0; foreach (bg_q[i]) ones += bg_q[i];
        checks++;
        if (to !== 0 || bg_q.size() != 3 || ones != 0) begin
            errors++; $display("FAIL bg_frame_b: got %0d of %0d set expected 0 of 3", ones, bg_q.size());
        end
        start_frame(2, 1, 32'h700);
        wait_done(to);
        ones = 0; foreach (bg_q[i]) ones += bg_q[i];
        checks++;
        if (to !== 0 || bg_q.size() != 2 || ones != 2) begin
            errors++; $display("FAIL bg_frame_c: got %0d of %0d set expected 2 of 2", ones, bg_q.size());
        end
        start_frame(1, 2, 32'h800);
        wait_done(to);
        ones = 0; foreach (bg_q[i]) ones += bg_q[i];
        checks++;
        if (to !== 0 || bg_q.size() != 2 || ones != 0) begin
            errors++; $display("FAIL bg_frame_d: got %0d of %0d set expected 0 of 2", ones, bg_q.size());
        end
    endtask

    task automatic test_zero_size(input logic [10:0] w, input logic [9:0] h);
        bit to;
        int r0, e0;
        r0 = req_cnt; e0 = en_tot;
        start_frame(w, h, 32'h900);
        wait_done(to);
        checks++;
        if (to !== 0 || done_cyc != start_cyc + 1) begin
            errors++; $display("FAIL zero_done_%0dx%0d: got cycle %0d expected %0d", w, h, done_cyc, start_cyc + 1);
        end
        checks++;
        if (req_cnt != r0 || en_tot != e0) begin
            errors++; $display("FAIL zero_activity_%0dx%0d: got %0d reqs %0d enables expected 0 0",
                               w, h, req_cnt - r0, en_tot - e0);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int d0, i, bad = 0;
        start_frame(4, 4, 32'hA00);
        d0 = done_cnt;
        for (i = 0; i < 200 && en_tot < 3; i++) @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (i == 200 || {mem_rd_req, enable, last_in_frame, wr_background, busy, frame_done} !== 6'b0
            || {rbg_pixel, memory_pixel} !== 64'h0) begin
            errors++;
            $display("FAIL abort_outputs: got ctl %b px %h mp %h expected all 0",
                     {mem_rd_req, enable, last_in_frame, wr_background, busy, frame_done}, rbg_pixel, memory_pixel);
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got %0d dones busy %b expected 0 dones busy 0", done_cnt - d0, busy);
        end
        start_frame(4, 4, 32'hA00);
        wait_done(to);
        foreach (px_q[k]) if (px_q[k] !== pat(32'hA00 + 4*k) || last_q[k] !== (k == 15)) bad++;
        checks++;
        if (to !== 0 || px_q.size() != 16 || bad != 0) begin
            errors++; $display("FAIL abort_restart: got %0d pixels %0d bad expected 16 pixels 0 bad", px_q.size(), bad);
        end
    endtask

    task automatic test_busy_start;
        bit to;
        int bad = 0;
        start_frame(4, 2, 32'h4000);
        repeat (2) @(posedge clk);
        #1 width = 7; height = 3; base_addr = 32'h8000; start = 1;
        @(posedge clk); #1 start = 0;
        wait_done(to);
        repeat (20) @(negedge clk);
        foreach (px_q[k]) if (px_q[k] !== pat(32'h4000 + 4*k)) bad++;
        checks++;
        if (to !== 0 || px_q.size() != 8 || bad != 0) begin
            errors++; $display("FAIL busy_pixels: got %0d pixels %0d bad expected 8 pixels 0 bad", px_q.size(), bad);
        end
        checks++;
        if (done_cnt - done_base != 1 || addr_q.size() != 8) begin
            errors++; $display("FAIL busy_ignored: got %0d dones %0d reqs expected 1 dones 8 reqs",
                               done_cnt - done_base, addr_q.size());
        end
        checks++;
        if (mp_err != 0) begin errors++; $display("FAIL memory_pixel_delay: got %0d mismatched cycles expected 0", mp_err); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_background();
        test_zero_size(0, 3);
        test_zero_size(5, 0);
        test_reset_mid();
        test_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
